booth_mul_sequencer: RTL and testbench
======================================

// Module: booth_mul_sequencer
// PURPOSE
//  Multi-cycle radix-4 Booth multiply controller for the CPU's MUL/MULU path.
//  Accepts one operand pair over a valid/ready handshake, retires one Booth group per clock
//  and loads the 2*WIDTH product into HI/LO output registers. Sits between the control unit
//  and the HI/LO register pair, replacing the combinational multiplier on the critical path.
// PARAMETERS
//  WIDTH  32  operand width; even, >= 4. Derived localparam ITERS = (WIDTH+2)/2 (17 at default).
// PORTS
//  clock            in   1      single clock, rising edge
//  clear_n          in   1      reset, asynchronous, active-low
//  start_valid      in   1      requester has an operation
//  start_ready      out  1      sequencer can accept (high only in IDLE)
//  op_signed        in   1      1 = signed x signed, 0 = unsigned x unsigned
//  multiplicand_in  in   WIDTH  M, sampled on handshake
//  multiplier_in    in   WIDTH  Q, sampled on handshake
//  abort            in   1      cancel the operation in flight
//  busy             out  1      high in RUN
//  done             out  1      one-cycle pulse: hi_out/lo_out hold a new product
//  hi_out           out  WIDTH  product[2*WIDTH-1:WIDTH], registered
//  lo_out           out  WIDTH  product[WIDTH-1:0], registered
// BEHAVIOUR
//  - Reset (clear_n=0, async): state=IDLE, acc/count=0, hi_out=lo_out=0, done=0, busy=0,
//    start_ready=1 once clear_n is deasserted. Reset mid-RUN discards the operation.
//  - FSM IDLE -> RUN -> DONE -> IDLE. No other states.
//  - IDLE: start_ready=1. Handshake = start_valid & start_ready at an edge: latch
//    M_ext = ext(M), Q_ext = ext(Q) to WIDTH+2 bits (sign-ext if op_signed, else zero-ext),
//    op_signed, acc=0, count=0 -> RUN. abort is ignored in IDLE.
//  - RUN: each edge, group g = {Q_ext[2c+1], Q_ext[2c], Q_ext[2c-1]}, where Q_ext[-1]=0 and
//    c=count. Recode: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
//    Negation = two's complement (~x+1) at full accumulator width. Partial product is
//    sign-extended to 2*WIDTH+4 bits, shifted left 2c, and added to acc; count++.
//  - On the edge where count == ITERS-1: the last group is added,
//    {hi_out, lo_out} <= (acc + pp)[2*WIDTH-1:0], state -> DONE.
//  - DONE: done=1 for exactly one cycle, start_ready=0, then -> IDLE.
//  - Latency: handshake at edge 0 -> done high in the cycle after edge ITERS.
//    Minimum handshake spacing is ITERS+2 cycles.
//  - abort=1 in RUN: -> IDLE at the next edge; no done; hi_out/lo_out keep their previous
//    values. abort=1 in DONE: ignored, done still pulses.
//  - start_valid held while busy: not accepted. Operands are re-sampled only at the
//    accepting edge. Inputs may change freely after the handshake.
//  - Signed overflow cannot occur: the full 2*WIDTH product is always exact.
//    The top 4 accumulator guard bits are discarded.
// STRUCTURE
//  - Shared package mul_pkg: FSM state enum {IDLE, RUN, DONE} (2-bit), Booth select enum
//    {PP_ZERO, PP_POS1, PP_POS2, PP_NEG1, PP_NEG2}, and a recode function 3b -> select.
//  - One sub-module: booth_pp_gen (select + M_ext -> sign-extended partial product,
//    combinational). FSM, counter, accumulator and HI/LO registers stay in this module.
// TESTING
//  1 signed 3 x -5 -> hi=FFFFFFFF lo=FFFFFFF1; done exactly 17 cycles after the handshake edge.
//  2 FFFFFFFF x FFFFFFFF: unsigned -> hi=FFFFFFFE lo=00000001; signed -> hi=0 lo=1.
//  3 signed 80000000 x 80000000 -> hi=40000000 lo=0; signed 80000000 x 1 -> hi=FFFFFFFF
//    lo=80000000.
//  4 complete 7x6 (lo=2A), start 9x9, abort on RUN cycle 5 -> no done, lo stays 2A,
//    start_ready=1 the next cycle.
//  5 clear_n low in RUN cycle 10 -> hi/lo/done/busy=0 immediately; after release, 2x2
//    gives lo=4 normally.
//  6 start_valid held high continuously with changing operands -> accepts spaced 19 cycles
//    apart; each product matches the operands sampled at its accepting edge.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types for the radix-4 Booth multiply sequencer: FSM states, partial-product
// selects and the 3-bit group recoder.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        PP_ZERO,
        PP_POS1,
        PP_POS2,
        PP_NEG1,
        PP_NEG2
    } pp_sel_e;

    function automatic pp_sel_e booth_recode(input logic [2:0] grp);
        pp_sel_e sel;
        case (grp)
            3'b001, 3'b010: sel = PP_POS1;
            3'b011:         sel = PP_POS2;
            3'b100:         sel = PP_NEG2;
            3'b101, 3'b110: sel = PP_NEG1;
            default:        sel = PP_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational Booth partial-product generator: turns a recoded select and the
// extended multiplicand into a sign-extended 0/+-M/+-2M term at accumulator width.
module booth_pp_gen
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]           sel_i,
    input  logic [WIDTH+1:0]     m_ext_i,
    output logic [2*WIDTH+3:0]   pp_o
);

    localparam int ACCW = 2 * WIDTH + 4;

    logic [ACCW-1:0] mx;
    logic [ACCW-1:0] mx2;

    assign mx  = {{(WIDTH + 2){m_ext_i[WIDTH+1]}}, m_ext_i};
    assign mx2 = mx << 1;

    always_comb begin
        pp_o = '0;
        case (pp_sel_e'(sel_i))
            PP_POS1: pp_o = mx;
            PP_POS2: pp_o = mx2;
            PP_NEG1: pp_o = ~mx + ACCW'(1);
            PP_NEG2: pp_o = ~mx2 + ACCW'(1);
            default: pp_o = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_sequencer.sv
// Multi-cycle radix-4 Booth multiplier: one Booth group retired per clock, full
// 2*WIDTH product loaded into the HI/LO output registers on completion.
module booth_mul_sequencer
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] multiplicand_in,
    input  logic [WIDTH-1:0] multiplier_in,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int EXTW  = WIDTH + 2;
    localparam int ACCW  = 2 * WIDTH + 4;
    localparam int ITERS = (WIDTH + 2) / 2;
    localparam int CW    = $clog2(ITERS + 1);

    state_e            state_q, state_d;
    logic [ACCW-1:0]   acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [EXTW-1:0]   mx_q, mx_d;
    logic [EXTW-1:0]   qx_q, qx_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;

    logic [EXTW:0]     qpad;
    logic [2:0]        grp;
    logic [ACCW-1:0]   pp;
    logic [ACCW-1:0]   pp_sh;
    logic [ACCW-1:0]   sum;

    // Q_ext[-1] is the implicit zero below bit 0, so the group for count c
    // sits at qpad[2c+2:2c].
    assign qpad  = {qx_q, 1'b0};
    assign grp   = 3'(qpad >> {cnt_q, 1'b0});
    assign pp_sh = pp << {cnt_q, 1'b0};
    assign sum   = acc_q + pp_sh;

    booth_pp_gen #(.WIDTH(WIDTH)) u_pp (
        .sel_i   (booth_recode(grp)),
        .m_ext_i (mx_q),
        .pp_o    (pp)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mx_d        = mx_q;
        qx_d        = qx_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        start_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    mx_d    = op_signed ? {{2{multiplicand_in[WIDTH-1]}}, multiplicand_in}
                                        : {2'b00, multiplicand_in};
                    qx_d    = op_signed ? {{2{multiplier_in[WIDTH-1]}}, multiplier_in}
                                        : {2'b00, multiplier_in};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                // Abort wins even on the final group: the result is never published.
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(ITERS - 1)) begin
                        {hi_d, lo_d} = sum[2*WIDTH-1:0];
                        state_d      = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            mx_q    <= '0;
            qx_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mx_q    <= mx_d;
            qx_q    <= qx_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Self-checking bench for booth_mul_sequencer: arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed products and latencies.
module tb_booth_mul_sequencer;

    localparam int W     = 32;
    localparam int ITERS = 17;

    logic          clock = 1'b0;
    logic          clear_n = 1'b0;
    logic          start_valid = 1'b0;
    logic          op_signed = 1'b0;
    logic [W-1:0]  mcand = '0;
    logic [W-1:0]  mplier = '0;
    logic          abort = 1'b0;
    logic          start_ready;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi_out;
    logic [W-1:0]  lo_out;

    int n_chk = 0;
    int n_pass = 0;

    booth_mul_sequencer #(.WIDTH(W)) dut (
        .clock           (clock),
        .clear_n         (clear_n),
        .start_valid     (start_valid),
        .start_ready     (start_ready),
        .op_signed       (op_signed),
        .multiplicand_in (mcand),
        .multiplier_in   (mplier),
        .abort           (abort),
        .busy            (busy),
        .done            (done),
        .hi_out          (hi_out),
        .lo_out          (lo_out)
    );

    always #5 clock = ~clock;

    // Reference: product by plain 64-bit arithmetic, timing as an in-flight countdown.
    logic          m_pend = 1'b0;
    logic          m_done = 1'b0;
    int            m_cnt = 0;
    logic [63:0]   m_prod = '0;
    logic [W-1:0]  m_hi = '0;
    logic [W-1:0]  m_lo = '0;

    function automatic logic [63:0] ref_prod(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = s ? {{32{a[W-1]}}, a} : {32'b0, a};
        bx = s ? {{32{b[W-1]}}, b} : {32'b0, b};
        return ax * bx;
    endfunction

    always @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            m_pend <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_pend) begin
                if (abort) begin
                    m_pend <= 1'b0;
                end else if (m_cnt == ITERS - 1) begin
                    m_pend <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= m_prod[63:32];
                    m_lo   <= m_prod[31:0];
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else if (!m_done && start_valid) begin
                m_pend <= 1'b1;
                m_cnt  <= 0;
                m_prod <= ref_prod(op_signed, mcand, mplier);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clock);
            if (clear_n) begin
                check("model_done", 64'(done), 64'(m_done));
                check("model_busy", 64'(busy), 64'(m_pend));
                check("model_ready", 64'(start_ready), 64'(!(m_pend || m_done)));
                check("model_hilo", {hi_out, lo_out}, {m_hi, m_lo});
            end
        end
    endtask

    task automatic go(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        k = 0;
        @(negedge clock);
        while (!start_ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (!start_ready) check("go_ready_timeout", 64'(start_ready), 64'(1));
        op_signed   = s;
        mcand       = a;
        mplier      = b;
        start_valid = 1'b1;
        @(posedge clock);
        #1;
        start_valid = 1'b0;
        op_signed   = ~s;
        mcand       = $urandom;
        mplier      = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check("done_timeout", 64'(done), 64'(1));
    endtask

    task automatic run(input string name, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int lat;
        go(s, a, b);
        wait_done(lat);
        check({name, "_latency"}, 64'(lat), 64'(ITERS));
        check({name, "_hi"}, 64'(hi_out), 64'(ehi));
        check({name, "_lo"}, 64'(lo_out), 64'(elo));
    endtask

    initial begin
        int prev;
        int nacc;
        logic seen;
        fork
            compare_loop();
        join_none

        #12;
        check("reset_hi", 64'(hi_out), 64'(0));
        check("reset_lo", 64'(lo_out), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        #3 clear_n = 1'b1;
        @(negedge clock);
        check("reset_ready", 64'(start_ready), 64'(1));

        run("t1_3x-5", 1'b1, 32'd3, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run("t2_uns_ff", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run("t2_sgn_ff", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
        run("t3_min_sq", 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run("t3_min_x1", 1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000);

        run("t4_7x6", 1'b0, 32'd7, 32'd6, 32'h0, 32'h2A);
        go(1'b0, 32'd9, 32'd9);
        repeat (4) @(posedge clock);
        #1 abort = 1'b1;
        @(posedge clock);
        #1 abort = 1'b0;
        @(negedge clock);
        check("t4_ready_after_abort", 64'(start_ready), 64'(1));
        check("t4_busy_after_abort", 64'(busy), 64'(0));
        check("t4_lo_kept", 64'(lo_out), 64'h2A);
        seen = 1'b0;
        repeat (25) begin
            @(negedge clock);
            if (done) seen = 1'b1;
        end
        check("t4_no_done", 64'(seen), 64'(0));

        go(1'b0, 32'd5, 32'd5);
        repeat (9) @(posedge clock);
        #1 clear_n = 1'b0;
        #1;
        check("t5_rst_hi", 64'(hi_out), 64'(0));
        check("t5_rst_lo", 64'(lo_out), 64'(0));
        check("t5_rst_done", 64'(done), 64'(0));
        check("t5_rst_busy", 64'(busy), 64'(0));
        @(negedge clock);
        #2 clear_n = 1'b1;
        run("t5_2x2", 1'b0, 32'd2, 32'd2, 32'h0, 32'h4);

        prev = -1;
        nacc = 0;
        @(negedge clock);
        start_valid = 1'b1;
        for (int i = 0; i < 70; i++) begin
            if (i > 0) @(negedge clock);
            op_signed = 1'($urandom);
            mcand     = $urandom;
            mplier    = $urandom;
            if (start_ready) begin
                if (prev >= 0) check("t6_spacing", 64'(i - prev), 64'(ITERS + 2));
                prev = i;
                nacc++;
            end
        end
        start_valid = 1'b0;
        check("t6_accepts", 64'(nacc), 64'(4));
        repeat (25) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
